seven_seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller that shares the single BCD-to-seven-segment decoder across NUM_DIGITS common-anode digits of the clock display.
- Holds a double-buffered snapshot of the digit values and presents one BCD nibble per slot to the decoder, with the matching active-low anode strobe.
- Inserts a dead-time between digits to prevent ghosting.
- Updates the snapshot only at frame boundaries so the display never tears.

---
 rtl/seven_seg_scan_ctrl_if.sv | 43 ++++
 rtl/seven_seg_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl_if
//   Bundles the display-side signals of the seven-segment scan controller.
//   The requester (clock logic or testbench) uses the master modport; the scan
//   controller uses the slave modport.
//
//   en          requester -> ctrl   display enable
//   digits_in   requester -> ctrl   BCD digits, nibble i is digit i
//   blank_mask  requester -> ctrl   1 = digit i never lit
//   lz_en       requester -> ctrl   suppress a zero in the top digit
//   load_req    requester -> ctrl   level request to capture digits/mask
//   load_ack    ctrl -> requester   one-cycle pulse, capture done
//   bcd_out     ctrl -> decoder     nibble presented to the segment decoder
//   an_n        ctrl -> display     active-low anode enables
//   digit_idx   ctrl -> requester   current slot index
//   frame_tick  ctrl -> requester   one-cycle pulse at each frame start
// -----------------------------------------------------------------------------
interface seven_seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);

   logic                    en;
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic                    lz_en;
   logic                    load_req;
   logic                    load_ack;
   logic [3:0]              bcd_out;
   logic [NUM_DIGITS-1:0]   an_n;
   logic [2:0]              digit_idx;
   logic                    frame_tick;

   modport master (
      output en, digits_in, blank_mask, lz_en, load_req,
      input  load_ack, bcd_out, an_n, digit_idx, frame_tick
   );

   modport slave (
      input  en, digits_in, blank_mask, lz_en, load_req,
      output load_ack, bcd_out, an_n, digit_idx, frame_tick
   );

endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//   Time-multiplexed scan controller for NUM_DIGITS common-anode digits sharing
//   one BCD-to-seven-segment decoder. Each slot is BLANK_CYC cycles with every
//   anode off followed by ON_CYC cycles with one anode driven. The digit values
//   live in a shadow copy that is only refreshed at frame boundaries so a frame
//   never shows a mix of old and new digits.
//
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seven_seg_scan_ctrl_if slave modport (inputs en, digits_in,
//          blank_mask, lz_en, load_req; outputs load_ack, bcd_out, an_n,
//          digit_idx, frame_tick -- all outputs registered)
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int ON_CYC     = 50000,
   parameter int BLANK_CYC  = 1000,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seven_seg_scan_ctrl_if.slave bus
);

   localparam int              IDX_W      = 3;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [3:0]       BCD_BLANK = 4'hF;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [4*NUM_DIGITS-1:0] shadow_digits;
   logic [NUM_DIGITS-1:0]   shadow_mask;
   // Set while the next enabled edge must start a fresh frame (after reset or
   // while the display is disabled).
   logic                    restart;
   // Whether the current slot's digit is lit; decided when the slot is entered
   // together with bcd_out so the anode and the nibble always agree.
   logic                    slot_lit;

   logic                    on_done;
   logic                    frame_edge;
   logic                    capture;
   logic [4*NUM_DIGITS-1:0] digits_nxt;
   logic [NUM_DIGITS-1:0]   mask_nxt;
   logic [IDX_W-1:0]        idx_nxt;
   logic [3:0]              nib_nxt;
   logic                    mask_bit_nxt;
   logic                    lit_nxt;
   logic [NUM_DIGITS-1:0]   an_on;

   // ---------------------------------------------------------------------------
   // Slot-entry decode: which digit comes next, and how it is shown. The shadow
   // value seen here is the post-capture one, so slot 0 of a frame that loads
   // new data shows the new value straight away.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment so
      // no path leaves it unassigned and no latch is inferred.
      on_done      = 1'b0;
      frame_edge   = 1'b0;
      capture      = 1'b0;
      digits_nxt   = shadow_digits;
      mask_nxt     = shadow_mask;
      idx_nxt      = digit_idx_plus_one(bus.digit_idx);
      nib_nxt      = BCD_BLANK;
      mask_bit_nxt = 1'b1;
      lit_nxt      = 1'b0;

      on_done    = (state == ST_ON) && (cnt == ON_LAST);
      frame_edge = bus.en && (restart || (on_done && (bus.digit_idx == LAST_IDX)));
      // While disabled a request is served on any edge; while scanning only at
      // a frame boundary.
      capture    = bus.load_req && (frame_edge || !bus.en);

      if (capture) begin
         digits_nxt = bus.digits_in;
         mask_nxt   = bus.blank_mask;
      end

      if (frame_edge) begin
         idx_nxt = '0;
      end

      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_nxt == IDX_W'(i)) begin
            nib_nxt      = digits_nxt[4*i +: 4];
            mask_bit_nxt = mask_nxt[i];
         end
      end

      // Leading-zero suppression applies only to the top digit.
      lit_nxt = !mask_bit_nxt &&
                !(bus.lz_en && (idx_nxt == LAST_IDX) && (nib_nxt == 4'h0));
   end

   // Anode pattern for the ON phase of the current slot.
   always_comb begin
      an_on = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (slot_lit && (bus.digit_idx == IDX_W'(i))) begin
            an_on[i] = 1'b0;
         end
      end
   end

   // Slot index after the current one, wrapping at the last digit.
   function automatic logic [IDX_W-1:0] digit_idx_plus_one(input logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] result;
      if (idx == LAST_IDX) begin
         result = '0;
      end else begin
         result = idx + IDX_W'(1);
      end
      return result;
   endfunction

   // ---------------------------------------------------------------------------
   // Scan FSM with registered outputs.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples values from before the edge regardless of statement order.
      if (!rst_n) begin
         state          <= ST_BLANK;
         cnt            <= '0;
         restart        <= 1'b1;
         slot_lit       <= 1'b0;
         // NOTE: the shadow is reset too, so a display coming out of reset stays
         // dark until the requester loads real digits.
         shadow_digits  <= '1;
         shadow_mask    <= '1;
         bus.an_n       <= '1;
         bus.bcd_out    <= BCD_BLANK;
         bus.digit_idx  <= '0;
         bus.load_ack   <= 1'b0;
         bus.frame_tick <= 1'b0;
      end else begin
         bus.load_ack   <= capture;
         bus.frame_tick <= frame_edge;

         if (capture) begin
            shadow_digits <= bus.digits_in;
            shadow_mask   <= bus.blank_mask;
         end

         if (!bus.en) begin
            state         <= ST_BLANK;
            cnt           <= '0;
            restart       <= 1'b1;
            slot_lit      <= 1'b0;
            bus.an_n      <= '1;
            bus.bcd_out   <= BCD_BLANK;
            bus.digit_idx <= '0;
         end else if (frame_edge || on_done) begin
            // Entering BLANK of the next slot: the only edge where the slot
            // index and bcd_out change, with every anode already off.
            state         <= ST_BLANK;
            cnt           <= '0;
            restart       <= 1'b0;
            slot_lit      <= lit_nxt;
            bus.an_n      <= '1;
            bus.bcd_out   <= lit_nxt ? nib_nxt : BCD_BLANK;
            bus.digit_idx <= idx_nxt;
         end else if (state == ST_BLANK) begin
            if (cnt == BLANK_LAST) begin
               state    <= ST_ON;
               cnt      <= '0;
               bus.an_n <= an_on;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//   Directed and randomized stimulus for seven_seg_scan_ctrl (4 digits, 8 ON
//   cycles, 2 BLANK cycles). A frame-position model predicts every output each
//   cycle from the time since the last frame start; a negedge monitor checks
//   the anode invariants.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

   localparam int N       = 4;
   localparam int ON_C    = 8;
   localparam int BLANK_C = 2;
   localparam int SLOT    = ON_C + BLANK_C;
   localparam int FRAME   = N * SLOT;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

   seven_seg_scan_ctrl #(
      .NUM_DIGITS(N),
      .ON_CYC    (ON_C),
      .BLANK_CYC (BLANK_C),
      .CNT_W     (16)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: position in frame plus a copy of the loaded digits.
   // ---------------------------------------------------------------------------
   bit         m_active;
   int         m_t;
   int         m_dig [N];
   bit         m_msk [N];
   bit         m_lit;
   int         m_nib;
   bit         m_ack;
   bit         m_tick;
   logic [3:0] e_an;
   logic [3:0] e_bcd;
   logic [2:0] e_idx;

   task automatic model_reset();
      m_active = 1'b0;
      m_t      = 0;
      for (int i = 0; i < N; i++) begin
         m_dig[i] = 15;
         m_msk[i] = 1'b1;
      end
      m_lit  = 1'b0;
      m_nib  = 15;
      m_ack  = 1'b0;
      m_tick = 1'b0;
      e_an   = 4'hF;
      e_bcd  = 4'hF;
      e_idx  = 3'd0;
   endtask

   task automatic model_capture();
      for (int i = 0; i < N; i++) begin
         m_dig[i] = int'(bus.digits_in[4*i +: 4]);
         m_msk[i] = bus.blank_mask[i];
      end
   endtask

   // Advance the model by one clock edge using the inputs as they are now.
   task automatic model_edge();
      int slot;
      int phase;
      if (!bus.en) begin
         m_ack  = bus.load_req;
         if (bus.load_req) model_capture();
         m_tick   = 1'b0;
         m_active = 1'b0;
         e_an     = 4'hF;
         e_bcd    = 4'hF;
         e_idx    = 3'd0;
      end else begin
         if (!m_active || m_t == FRAME - 1) begin
            m_t      = 0;
            m_active = 1'b1;
            m_tick   = 1'b1;
            m_ack    = bus.load_req;
            if (bus.load_req) model_capture();
         end else begin
            m_t++;
            m_tick = 1'b0;
            m_ack  = 1'b0;
         end
         slot  = m_t / SLOT;
         phase = m_t % SLOT;
         if (phase == 0) begin
            m_nib = m_dig[slot];
            m_lit = !m_msk[slot] && !(bus.lz_en && slot == N - 1 && m_nib == 0);
         end
         e_idx = 3'(slot);
         e_bcd = m_lit ? 4'(m_nib) : 4'hF;
         e_an  = 4'hF;
         if (phase >= BLANK_C && m_lit) e_an[slot] = 1'b0;
      end
   endtask

   task automatic compare_all();
      check("an_n",       32'(bus.an_n),       32'(e_an));
      check("bcd_out",    32'(bus.bcd_out),    32'(e_bcd));
      check("digit_idx",  32'(bus.digit_idx),  32'(e_idx));
      check("load_ack",   32'(bus.load_ack),   32'(m_ack));
      check("frame_tick", 32'(bus.frame_tick), 32'(m_tick));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   // Hold load_req until the model predicts the acknowledge, then drop it.
   task automatic load(input logic [15:0] d, input logic [3:0] m, input logic lz);
      bit acked;
      acked          = 1'b0;
      bus.digits_in  = d;
      bus.blank_mask = m;
      bus.lz_en      = lz;
      bus.load_req   = 1'b1;
      for (int i = 0; i < 2 * FRAME && !acked; i++) begin
         step();
         acked = m_ack;
      end
      bus.load_req = 1'b0;
      check("load_acked_in_time", 32'(acked), 32'd1);
   endtask

   task automatic run_until_t(input int t);
      bit hit;
      hit = m_active && m_t == t;
      for (int i = 0; i < 2 * FRAME && !hit; i++) begin
         step();
         hit = m_active && m_t == t;
      end
      check("reached_frame_pos", 32'(hit), 32'd1);
   endtask

   // ---------------------------------------------------------------------------
   // Anode invariants: never two digits on, and dark whenever the index moves.
   // ---------------------------------------------------------------------------
   logic [2:0] prev_idx = 3'd0;

   always @(negedge clk) begin
      if (rst_n) begin
         check("an_onehot", 32'($countones(~bus.an_n) <= 1), 32'd1);
         if (bus.digit_idx != prev_idx) check("an_dark_on_idx_change", 32'(bus.an_n), 32'hF);
      end
      prev_idx = bus.digit_idx;
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [15:0] rd;
      logic [3:0]  rm;

      bus.en         = 1'b0;
      bus.digits_in  = '0;
      bus.blank_mask = '0;
      bus.lz_en      = 1'b0;
      bus.load_req   = 1'b0;
      model_reset();

      #1 rst_n = 1'b0;
      #1;
      compare_all();
      repeat (2) @(posedge clk);
      #1;
      compare_all();

      // Release and scan one frame with the reset shadow: display stays dark.
      rst_n  = 1'b1;
      bus.en = 1'b1;
      run(FRAME);

      // Basic load and two full frames of 1234.
      load(16'h1234, 4'b0000, 1'b0);
      run(2 * FRAME);

      // Leading-zero suppression on the top digit, then disabled.
      load(16'h0930, 4'b0000, 1'b1);
      run(FRAME);
      bus.lz_en = 1'b0;
      run(FRAME + 5);

      // Request raised mid-frame: current frame keeps the old digits.
      run_until_t(15);
      load(16'h5678, 4'b0000, 1'b0);
      run(FRAME);

      // Randomized digits, masks and leading-zero enable.
      for (int k = 0; k < 6; k++) begin
         rd = 16'($urandom);
         rm = 4'($urandom & $urandom);
         load(rd, rm, 1'($urandom_range(0, 1)));
         run($urandom_range(FRAME / 2, FRAME + 7));
      end

      // Drop en in the middle of slot 2, load while disabled, re-enable.
      load(16'h4321, 4'b0000, 1'b0);
      run_until_t(2 * SLOT + 5);
      bus.en = 1'b0;
      run(3);
      load(16'h8765, 4'b0010, 1'b0);
      run(2);
      bus.en = 1'b1;
      run(FRAME + 3);

      // Reset in the ON phase of a slot, between clock edges.
      run_until_t(SLOT + 6);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      #2 rst_n = 1'b1;
      run(FRAME);
      load(16'h2468, 4'b0000, 1'b1);
      run(FRAME);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
